// File: rtl/layer5_argmax.sv
// -----------------------------------------------------------------------------
// layer5_argmax
//
// Final classification stage behind the layer-5 FC controller/MAC. The block
// captures NUM_CLASS signed scores, one per score strobe, into a small buffer.
// It keeps a running maximum while the scores arrive and presents the winning
// class index and score on a valid/ack handshake. Stored scores can be read
// back for debug through a registered read port.
//
// Ports
//   clk_i      clock
//   rst_i      synchronous, active-high reset
//   start_i    new-image pulse; clears the collection and enters COLLECT
//   wr_i       score strobe from the layer-5 controller
//   data_i     signed score, sampled when wr_i=1
//   ack_i      consumer acknowledges the result
//   rd_addr_i  debug readback address
//   rd_data_o  debug readback data (1-cycle latency, 0 when out of range)
//   class_o    winning class index
//   score_o    winning score
//   valid_o    result valid
//   busy_o     high while collecting scores
//   err_o      sticky protocol error (stray write in IDLE or DONE)
//   img_cnt_o  number of results produced (wraps)
// -----------------------------------------------------------------------------
module layer5_argmax #(
   parameter int DATA_W    = 32,
   parameter int NUM_CLASS = 10,
   parameter int IDX_W     = 4,
   parameter int CNT_W     = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   input  logic              wr_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic              ack_i,
   input  logic [IDX_W-1:0]  rd_addr_i,
   output logic [DATA_W-1:0] rd_data_o,
   output logic [IDX_W-1:0]  class_o,
   output logic [DATA_W-1:0] score_o,
   output logic              valid_o,
   output logic              busy_o,
   output logic              err_o,
   output logic [CNT_W-1:0]  img_cnt_o
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_DONE    = 2'd2
   } state_t;

   state_t                    r_state;
   logic [DATA_W-1:0]         r_buf [NUM_CLASS];
   logic [IDX_W-1:0]          r_wr_cnt;
   logic signed [DATA_W-1:0]  r_max_val;
   logic [IDX_W-1:0]          r_max_idx;
   logic [IDX_W-1:0]          r_class;
   logic [DATA_W-1:0]         r_score;
   logic                      r_valid;
   logic                      r_busy;
   logic                      r_err;
   logic [CNT_W-1:0]          r_img_cnt;
   logic [DATA_W-1:0]         r_rd_data;

   logic                      w_take_max;
   logic                      w_last;
   logic                      w_rd_in_range;
   logic signed [DATA_W-1:0]  w_max_val_nxt;
   logic [IDX_W-1:0]          w_max_idx_nxt;

   // The first score of an image always seeds the maximum; later scores win
   // only when strictly greater, so a tie keeps the lower index.
   assign w_take_max    = (r_wr_cnt == '0) || ($signed(data_i) > r_max_val);
   assign w_max_val_nxt = w_take_max ? $signed(data_i) : r_max_val;
   assign w_max_idx_nxt = w_take_max ? r_wr_cnt : r_max_idx;
   assign w_last        = (int'(r_wr_cnt) == NUM_CLASS - 1);
   assign w_rd_in_range = (int'(rd_addr_i) < NUM_CLASS);

   // NOTE: every register below is assigned with <= so that all state updates
   // on an edge see the pre-edge values (e.g. a same-address read returns the
   // old buffer contents).
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state   <= S_IDLE;
         r_wr_cnt  <= '0;
         r_max_val <= '0;
         r_max_idx <= '0;
         r_class   <= '0;
         r_score   <= '0;
         r_valid   <= 1'b0;
         r_busy    <= 1'b0;
         r_err     <= 1'b0;
         r_img_cnt <= '0;
         r_rd_data <= '0;
         // NOTE: the score buffer is reset explicitly because a freshly reset
         // block must read back zeros; it is only NUM_CLASS entries deep, so
         // it is built from flops rather than a RAM macro.
         for (int i = 0; i < NUM_CLASS; i++) begin
            r_buf[i] <= '0;
         end
      end else begin
         // Debug readback runs in every state.
         r_rd_data <= w_rd_in_range ? r_buf[rd_addr_i] : '0;

         if (start_i) begin
            // A new image overrides everything in flight, including a
            // same-cycle write or ack. The buffer is deliberately kept.
            r_state   <= S_COLLECT;
            r_wr_cnt  <= '0;
            r_max_val <= '0;
            r_max_idx <= '0;
            r_valid   <= 1'b0;
            r_busy    <= 1'b1;
            r_err     <= 1'b0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (wr_i) begin
                     r_err <= 1'b1;
                  end
               end

               S_COLLECT: begin
                  if (wr_i) begin
                     r_buf[r_wr_cnt] <= data_i;
                     r_max_val       <= w_max_val_nxt;
                     r_max_idx       <= w_max_idx_nxt;
                     if (w_last) begin
                        // Publish the final maximum, including this write.
                        r_state   <= S_DONE;
                        r_wr_cnt  <= '0;
                        r_class   <= w_max_idx_nxt;
                        r_score   <= w_max_val_nxt;
                        r_valid   <= 1'b1;
                        r_busy    <= 1'b0;
                        r_img_cnt <= r_img_cnt + 1'b1;
                     end else begin
                        r_wr_cnt <= r_wr_cnt + 1'b1;
                     end
                  end
               end

               S_DONE: begin
                  if (wr_i) begin
                     r_err <= 1'b1;
                  end
                  if (ack_i) begin
                     r_state <= S_IDLE;
                     r_valid <= 1'b0;
                  end
               end

               default: begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                  r_valid <= 1'b0;
               end
            endcase
         end
      end
   end

   assign rd_data_o = r_rd_data;
   assign class_o   = r_class;
   assign score_o   = r_score;
   assign valid_o   = r_valid;
   assign busy_o    = r_busy;
   assign err_o     = r_err;
   assign img_cnt_o = r_img_cnt;

endmodule

// File: tb/tb_layer5_argmax.sv
// -----------------------------------------------------------------------------
// tb_layer5_argmax
//
// Directed and randomized bench for layer5_argmax. Expected results come from a
// small reference model: an array copy of the score buffer, an image counter
// and a plain "first index holding the largest value" search.
// -----------------------------------------------------------------------------
module tb_layer5_argmax;

   localparam int DATA_W    = 32;
   localparam int NUM_CLASS = 10;
   localparam int IDX_W     = 4;
   localparam int CNT_W     = 16;

   logic              clk_i;
   logic              rst_i;
   logic              start_i;
   logic              wr_i;
   logic [DATA_W-1:0] data_i;
   logic              ack_i;
   logic [IDX_W-1:0]  rd_addr_i;
   logic [DATA_W-1:0] rd_data_o;
   logic [IDX_W-1:0]  class_o;
   logic [DATA_W-1:0] score_o;
   logic              valid_o;
   logic              busy_o;
   logic              err_o;
   logic [CNT_W-1:0]  img_cnt_o;

   layer5_argmax #(
      .DATA_W    (DATA_W),
      .NUM_CLASS (NUM_CLASS),
      .IDX_W     (IDX_W),
      .CNT_W     (CNT_W)
   ) dut (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .start_i   (start_i),
      .wr_i      (wr_i),
      .data_i    (data_i),
      .ack_i     (ack_i),
      .rd_addr_i (rd_addr_i),
      .rd_data_o (rd_data_o),
      .class_o   (class_o),
      .score_o   (score_o),
      .valid_o   (valid_o),
      .busy_o    (busy_o),
      .err_o     (err_o),
      .img_cnt_o (img_cnt_o)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state
   int model_buf [NUM_CLASS];
   int model_img = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock; outputs are sampled 1 ns after the rising edge.
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   // Winner = lowest index holding the largest signed score.
   function automatic int ref_argmax(input int s [NUM_CLASS]);
      int best = 0;
      for (int i = 1; i < NUM_CLASS; i++) begin
         if (s[i] > s[best]) best = i;
      end
      return best;
   endfunction

   task automatic pulse_start();
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      check("start_busy", busy_o, 1);
      check("start_valid", valid_o, 0);
      check("start_err", err_o, 0);
   endtask

   task automatic pulse_ack();
      ack_i = 1'b1;
      tick();
      ack_i = 1'b0;
      check("ack_valid", valid_o, 0);
      check("ack_busy", busy_o, 0);
   endtask

   // Feed one full image, random gaps up to max_gap idle cycles between writes.
   // With chk_rd0 set, rd_addr_i is 0 during the first write and the read must
   // return the buffer's previous contents.
   task automatic write_image(input int s [NUM_CLASS], input int max_gap, input bit chk_rd0);
      int old0;
      old0 = model_buf[0];
      for (int i = 0; i < NUM_CLASS; i++) begin
         data_i = s[i];
         wr_i   = 1'b1;
         tick();
         wr_i   = 1'b0;
         if (i == 0 && chk_rd0) check("rd_same_addr_old", rd_data_o, old0);
         model_buf[i] = s[i];
         if (i < NUM_CLASS - 1) begin
            check("collect_busy", busy_o, 1);
            check("collect_no_valid", valid_o, 0);
            repeat ($urandom_range(0, max_gap)) begin
               tick();
               check("gap_busy", busy_o, 1);
            end
         end
      end
      model_img++;
   endtask

   task automatic check_result(input string tag, input int s [NUM_CLASS]);
      int w;
      w = ref_argmax(s);
      check({tag, "_valid"}, valid_o, 1);
      check({tag, "_class"}, class_o, w);
      check({tag, "_score"}, score_o, s[w]);
      check({tag, "_img_cnt"}, img_cnt_o, model_img);
      check({tag, "_busy"}, busy_o, 0);
      check({tag, "_err"}, err_o, 0);
   endtask

   task automatic readback(input string tag, input int addr, input int exp);
      rd_addr_i = IDX_W'(addr);
      tick();
      check(tag, rd_data_o, exp);
   endtask

   task automatic check_reset_state();
      check("rst_class", class_o, 0);
      check("rst_score", score_o, 0);
      check("rst_valid", valid_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_err", err_o, 0);
      check("rst_img_cnt", img_cnt_o, 0);
      check("rst_rd_data", rd_data_o, 0);
   endtask

   initial begin
      int s1 [NUM_CLASS] = '{5, -3, 100, 7, 100, 2, 0, -50, 99, 1};
      int s2 [NUM_CLASS] = '{-10, -9, -8, -20, -1, -5, -7, -3, -2, -4};
      int s [NUM_CLASS];
      int held_class;

      rst_i = 1'b1; start_i = 1'b0; wr_i = 1'b0; data_i = '0;
      ack_i = 1'b0; rd_addr_i = '0;
      for (int i = 0; i < NUM_CLASS; i++) model_buf[i] = 0;

      // Reset
      tick(); tick();
      rst_i = 1'b0;
      check_reset_state();
      readback("rst_buf_rd", 5, 0);

      // Image 1: back-to-back writes, tie at idx 4 must lose to idx 2
      pulse_start();
      write_image(s1, 0, 1'b0);
      check_result("img1", s1);
      pulse_ack();

      // Image 2: all negative, random gaps
      pulse_start();
      write_image(s2, 5, 1'b0);
      check_result("img2", s2);

      // Hold result without ack, then ack, then stray write in IDLE
      held_class = ref_argmax(s2);
      for (int c = 0; c < 20; c++) begin
         tick();
         check("hold_valid", valid_o, 1);
         check("hold_class", class_o, held_class);
      end
      pulse_ack();
      check("post_ack_class", class_o, held_class);
      check("post_ack_score", score_o, s2[held_class]);
      data_i = 32'd12345;
      wr_i = 1'b1;
      tick();
      wr_i = 1'b0;
      check("idle_wr_err", err_o, 1);
      check("idle_wr_busy", busy_o, 0);
      for (int a = 0; a < NUM_CLASS; a++) readback("buf_unchanged", a, model_buf[a]);

      // ack with no valid result is ignored
      ack_i = 1'b1;
      tick();
      ack_i = 1'b0;
      check("idle_ack_valid", valid_o, 0);
      check("idle_ack_err", err_o, 1);

      // Restart after 4 writes; new image has its max at idx 9
      pulse_start();
      for (int i = 0; i < 4; i++) begin
         data_i = 32'd1000;
         wr_i = 1'b1;
         tick();
         wr_i = 1'b0;
         model_buf[i] = 1000;
      end
      pulse_start();
      for (int i = 0; i < NUM_CLASS - 1; i++) s[i] = int'($urandom_range(0, 1000)) - 500;
      s[NUM_CLASS-1] = 32'h7FFF_FFFF;
      write_image(s, 2, 1'b0);
      check_result("img_restart", s);
      check("img_restart_max9", class_o, 9);

      // Stray write in DONE sets err; start+ack together: start wins
      data_i = 32'd55;
      wr_i = 1'b1;
      tick();
      wr_i = 1'b0;
      check("done_wr_err", err_o, 1);
      check("done_wr_valid", valid_o, 1);
      start_i = 1'b1;
      ack_i   = 1'b1;
      tick();
      start_i = 1'b0;
      ack_i   = 1'b0;
      check("start_ack_busy", busy_o, 1);
      check("start_ack_valid", valid_o, 0);
      check("start_ack_err", err_o, 0);

      // start and wr together: write dropped; write/read same address
      rd_addr_i = '0;
      start_i = 1'b1;
      wr_i = 1'b1;
      data_i = 32'd777;
      tick();
      start_i = 1'b0;
      wr_i = 1'b0;
      check("start_wr_busy", busy_o, 1);
      check("start_wr_err", err_o, 0);
      for (int i = 0; i < NUM_CLASS; i++) s[i] = int'($urandom());
      write_image(s, 1, 1'b1);
      check_result("img_start_wr", s);
      readback("rd_addr3", 3, s[3]);
      readback("rd_addr12", 12, 0);
      pulse_ack();

      // Reset after the 6th write aborts everything
      pulse_start();
      for (int i = 0; i < 6; i++) begin
         data_i = 32'(i + 40);
         wr_i = 1'b1;
         tick();
         wr_i = 1'b0;
      end
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      check_reset_state();
      for (int i = 0; i < NUM_CLASS; i++) model_buf[i] = 0;
      model_img = 0;
      readback("rst_buf_clr", 2, 0);

      pulse_start();
      for (int i = 0; i < NUM_CLASS; i++) s[i] = int'($urandom());
      write_image(s, 3, 1'b0);
      check_result("img_after_rst", s);
      pulse_ack();

      // Random images with full-range signed scores
      for (int n = 0; n < 3; n++) begin
         pulse_start();
         for (int i = 0; i < NUM_CLASS; i++) s[i] = int'($urandom());
         write_image(s, 3, 1'b0);
         check_result("img_rand", s);
         readback("rand_rd", n + 5, model_buf[n + 5]);
         pulse_ack();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
